// File: rtl/cir_seq_ctrl_if.sv
// Handshake/bus bundle between the sequence controller and its client side.
// master = client/plant side (drives requests and y), slave = controller.
interface cir_seq_ctrl_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       req;
  logic [1:0]       tgt0;
  logic [1:0]       tgt1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             y_in;
  logic             a_out;
  logic [1:0]       sh_state;
  logic             busy;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             err;

  modport master (
    output req, tgt0, tgt1, len0, len1, y_in,
    input  a_out, sh_state, busy, gnt, done, err
  );

  modport slave (
    input  req, tgt0, tgt1, len0, len1, y_in,
    output a_out, sh_state, busy, gnt, done, err
  );
endinterface

// File: rtl/cir_seq_ctrl.sv
// Sequence controller for a shared 4-state toggle FSM. Two clients are
// arbitrated round-robin; the winner's target state is navigated to, then
// visited len+1 times (dwelling by toggling bit0), then done is pulsed.
// A shadow copy of the shared FSM state is kept so a_out depends only on
// registered state.
module cir_seq_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  cir_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, NAV, DWELL} st_t;

  st_t              st;
  logic [1:0]       sh;
  logic [1:0]       tgt_l;
  logic [LEN_W-1:0] len_l;
  logic [LEN_W-1:0] cnt;
  logic             own;
  logic             last;
  logic             busy_r;
  logic             err_r;
  logic [1:0]       gnt_r;
  logic [1:0]       done_r;
  logic             a_out;
  logic             win;
  logic             visit;
  logic             fin;

  assign visit = (st != IDLE) && (sh == tgt_l);
  assign fin   = visit && (cnt == len_l);

  // Shared FSM drive: only NAV off-target steers, bit0 difference first.
  always_comb begin
    a_out = 1'b0;
    if (st == NAV && sh != tgt_l)
      a_out = ~(sh[0] ^ tgt_l[0]);
  end

  // Round-robin pick: on a tie, the client not served last wins.
  always_comb begin
    win = bus.req[1];
    if (bus.req == 2'b11)
      win = ~last;
  end

  // Controller FSM, shadow tracking, pulses and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st     <= IDLE;
      sh     <= 2'b00;
      tgt_l  <= 2'b00;
      len_l  <= '0;
      cnt    <= '0;
      own    <= 1'b0;
      last   <= 1'b1;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
    end else begin
      sh     <= sh ^ (a_out ? 2'b10 : 2'b01);
      err_r  <= err_r | (bus.y_in != a_out);
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
      case (st)
        IDLE: begin
          if (|bus.req) begin
            own    <= win;
            last   <= win;
            tgt_l  <= win ? bus.tgt1 : bus.tgt0;
            len_l  <= win ? bus.len1 : bus.len0;
            cnt    <= '0;
            st     <= NAV;
            busy_r <= 1'b1;
            gnt_r  <= win ? 2'b10 : 2'b01;
          end
        end
        NAV, DWELL: begin
          if (fin) begin
            st     <= IDLE;
            busy_r <= 1'b0;
            done_r <= own ? 2'b10 : 2'b01;
          end else if (visit) begin
            cnt <= cnt + 1'b1;
            st  <= DWELL;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.a_out    = a_out;
  assign bus.sh_state = sh;
  assign bus.busy     = busy_r;
  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: doc/cir_seq_ctrl.md
CIR_SEQ_CTRL -- requirements
Module: cir_seq_ctrl

Interface
REQ-001 The block SHALL expose the parameter LEN_W, default 4, giving the width of each dwell-length field.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req  input  2  per-client request; bit i set = client i requests.
REQ-005 tgt0, tgt1  input  2 each  target state (0..3) of client 0 and client 1.
REQ-006 len0, len1  input  LEN_W each  dwell count of client 0 and client 1; number of target visits = len+1.
REQ-007 y_in  input  1  output y returned from the shared 4-state toggle FSM.
REQ-008 a_out  output  1  drives input A of the shared FSM.
REQ-009 sh_state  output  2  shadow copy of the shared FSM state.
REQ-010 busy  output  1  high in NAV and DWELL.
REQ-011 gnt  output  2  one-cycle grant pulse per client.
REQ-012 done  output  2  one-cycle completion pulse per client.
REQ-013 err  output  1  sticky wiring/consistency error flag.

Function
REQ-014 The shared FSM advances every clock: A=0 toggles state bit0, A=1 toggles state bit1. The shadow register SHALL track it: sh_next = sh ^ (a_out ? 2'b10 : 2'b01), every cycle, in all controller states.
REQ-015 a_out SHALL be a combinational function of registered state only (ctrl state, sh, latched tgt), never of inputs.
REQ-016 Controller states SHALL be IDLE, NAV and DWELL.
REQ-017 IDLE: a_out=0. Req is sampled only in IDLE. If any req bit is set, the block SHALL select the owner, latch its tgt and len, clear the visit counter, go to NAV, and assert gnt[owner] in the first NAV cycle.
REQ-018 Arbitration SHALL be round-robin. A lone requester wins. On a tie, the client not served last wins; client 0 wins the first tie after reset.
REQ-019 NAV with sh!=tgt: a_out=0 if (sh^tgt) bit0 is set, else a_out=1; the state stays NAV.
REQ-020 A visit SHALL be any NAV or DWELL cycle with sh==tgt.
- The visit counter increments on each visit.
- a_out=0 on a visit cycle.
- A NAV visit that is not final moves to DWELL.
REQ-021 DWELL: a_out=0, so sh alternates tgt, tgt^1.
REQ-022 The final visit is the visit at which the counter equals len. On the final visit the next state SHALL be IDLE, and done[owner] SHALL pulse in the following (IDLE) cycle.
REQ-023 Timing: NAV lasts popcount(sh^tgt at NAV entry)+1 cycles. DWELL lasts 2*len cycles. done follows one cycle later.
REQ-024 A req still high in the done cycle SHALL be treated as a new request, subject to REQ-018.
REQ-025 busy=1 in NAV and DWELL, and 0 otherwise; gnt and done SHALL never be asserted for both clients in the same cycle.
REQ-026 err SHALL set on any cycle with y_in != a_out and stay set until reset.
REQ-027 len=0 SHALL skip DWELL. len=2^LEN_W-1 SHALL give 2^LEN_W visits, with no counter wrap before the final visit.

Reset
REQ-028 While rst=0 at an edge, the block SHALL clear the following, with outputs showing these values from the next cycle:
- ctrl state=IDLE, sh=0, visit counter=0;
- a_out=0, busy=0, gnt=0, done=0, err=0;
- round-robin pointer favouring client 0.
REQ-029 Reset mid-NAV or mid-DWELL SHALL abort with no done pulse; the aborted request is not remembered.

Verification
REQ-030 Idle: release rst, no req -> a_out=0, sh_state 0,1,0,1..., busy/gnt/done/err=0.
REQ-031 Navigate: req0=1, tgt0=3, len0=0 in the first cycle after reset (sh=0) -> next cycles:
- sh 1 (gnt0=1, a_out=1);
- sh 3 (a_out=0, final visit);
- IDLE with done0=1, busy=0.
REQ-032 Dwell: grant client 1 with tgt1=2, len1=2 -> sh visits 2 three times, with 3 between visits, a_out=0 through DWELL; done1 comes one cycle after the third visit; DWELL spans 4 cycles.
REQ-033 Arbitration: req=2'b11 held after reset -> gnt0 first, then gnt1 after done0. With both re-requesting, grants alternate 0,1,0...
REQ-034 Reset mid-DWELL: rst=0 for one edge -> next cycle IDLE, sh=0, busy=0, no done pulse.
REQ-035 Error: force y_in to the inverse of a_out for one cycle -> err=1 from the next cycle, held until rst=0.
